// File: rtl/div_unit_m1.sv
// Iterative 16-bit radix-2 restoring divider feeding the writeback stage.
// Handles signed/unsigned quotient or remainder; one operation in flight at a time.
module div_unit_m1 (
  input  logic        clk,
  input  logic        sync_rst_n,
  input  logic        clk_en,
  input  logic        flush,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  input  logic        is_signed,
  input  logic        want_rem,
  input  logic [3:0]  dest_addr,
  input  logic        wb_stall,
  output logic [15:0] div_data,
  output logic [3:0]  div_dest_addr,
  output logic        div_valid,
  output logic        busy,
  output logic [2:0]  state_dbg
);

  // Handshake: an operation transfers on a rising edge where clk_en, issue_valid
  // and issue_ready are all high and flush is low; issue_ready depends on state only.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [15:0] op_a, op_b;
  logic        op_signed, op_rem;
  logic [3:0]  op_dest;
  logic        neg_q, neg_r, div_zero;
  logic [15:0] rem_q, quo_q, dvs_abs;
  logic [3:0]  cnt;

  logic [16:0] rem_sh;
  logic        rem_ge;
  logic [15:0] rem_sub;
  logic [15:0] a_abs, b_abs;
  logic [15:0] q_fix, r_fix;

  assign issue_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign state_dbg   = state;

  always_comb begin
    rem_sh  = {rem_q, quo_q[15]};
    rem_ge  = (rem_sh >= {1'b0, dvs_abs});
    rem_sub = rem_sh[15:0] - dvs_abs;
    a_abs   = (op_signed && op_a[15]) ? (~op_a + 16'd1) : op_a;
    b_abs   = (op_signed && op_b[15]) ? (~op_b + 16'd1) : op_b;
    // Divide-by-zero results are architectural constants, never sign-corrected.
    q_fix   = (neg_q && !div_zero) ? (~quo_q + 16'd1) : quo_q;
    r_fix   = (neg_r && !div_zero) ? (~rem_q + 16'd1) : rem_q;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (issue_valid) state_nxt = PREP;
        PREP: state_nxt = (op_b == 16'd0) ? FIX : ITER;
        ITER: if (cnt == 4'd0) state_nxt = FIX;
        FIX:  state_nxt = DONE;
        DONE: if (!wb_stall) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      state <= IDLE;
    end else if (clk_en) begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      op_a          <= 16'd0;
      op_b          <= 16'd0;
      op_signed     <= 1'b0;
      op_rem        <= 1'b0;
      op_dest       <= 4'd0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      div_zero      <= 1'b0;
      rem_q         <= 16'd0;
      quo_q         <= 16'd0;
      dvs_abs       <= 16'd0;
      cnt           <= 4'd0;
      div_data      <= 16'd0;
      div_dest_addr <= 4'd0;
      div_valid     <= 1'b0;
    end else if (clk_en) begin
      if (flush) begin
        div_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (issue_valid) begin
              op_a      <= dividend;
              op_b      <= divisor;
              op_signed <= is_signed;
              op_rem    <= want_rem;
              op_dest   <= dest_addr;
            end
          end
          PREP: begin
            neg_q   <= op_signed & (op_a[15] ^ op_b[15]);
            neg_r   <= op_signed & op_a[15];
            dvs_abs <= b_abs;
            cnt     <= 4'd15;
            if (op_b == 16'd0) begin
              div_zero <= 1'b1;
              quo_q    <= 16'hFFFF;
              rem_q    <= op_a;
            end else begin
              div_zero <= 1'b0;
              quo_q    <= a_abs;
              rem_q    <= 16'd0;
            end
          end
          ITER: begin
            // Restoring step: keep the subtraction only when it does not go negative.
            rem_q <= rem_ge ? rem_sub : rem_sh[15:0];
            quo_q <= {quo_q[14:0], rem_ge};
            if (cnt != 4'd0) cnt <= cnt - 4'd1;
          end
          FIX: begin
            div_data      <= op_rem ? r_fix : q_fix;
            div_dest_addr <= op_dest;
            div_valid     <= 1'b1;
          end
          DONE: begin
            if (!wb_stall) div_valid <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_unit_m1.sv
// Directed bench for div_unit_m1: arithmetic cases, latency, stall hold,
// flush, reset and clock-enable behaviour, checked with immediate assertions.
module tb_div_unit_m1;

  logic        clk = 1'b0;
  logic        sync_rst_n, clk_en, flush, issue_valid, is_signed, want_rem, wb_stall;
  logic [15:0] dividend, divisor;
  logic [3:0]  dest_addr;
  logic        issue_ready, div_valid, busy;
  logic [15:0] div_data;
  logic [3:0]  div_dest_addr;
  logic [2:0]  state_dbg;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_edge;
  int lat;
  logic timed_out;
  logic [15:0] held;

  div_unit_m1 dut (
    .clk(clk), .sync_rst_n(sync_rst_n), .clk_en(clk_en), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .dividend(dividend), .divisor(divisor), .is_signed(is_signed),
    .want_rem(want_rem), .dest_addr(dest_addr), .wb_stall(wb_stall),
    .div_data(div_data), .div_dest_addr(div_dest_addr), .div_valid(div_valid),
    .busy(busy), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Presents one operation for a single cycle; n_edge records the handshake edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic sgn,
                       input logic rem, input logic [3:0] dst);
    issue_valid = 1'b1;
    dividend    = a;
    divisor     = b;
    is_signed   = sgn;
    want_rem    = rem;
    dest_addr   = dst;
    @(negedge clk);
    n_edge      = cyc;
    issue_valid = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (div_valid) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
    lat = cyc - n_edge;
    if (timed_out) begin
      checks++;
      failures++;
      $error("FAIL wait_valid timeout after %0d cycles", budget);
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic sgn, input logic rem, input logic [3:0] dst,
                        input logic [15:0] exp_data, input int exp_lat);
    issue(a, b, sgn, rem, dst);
    wait_valid(40);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_data"}, div_data, exp_data);
    check({tag, "_dest"}, div_dest_addr, dst);
    @(negedge clk);
    check({tag, "_valid_drop"}, div_valid, 1'b0);
    check({tag, "_ready_back"}, issue_ready, 1'b1);
  endtask

  initial begin
    sync_rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0; issue_valid = 1'b0;
    is_signed = 1'b0; want_rem = 1'b0; wb_stall = 1'b0;
    dividend = 16'd0; divisor = 16'd0; dest_addr = 4'd0;
    step(3);
    check("rst_valid", div_valid, 1'b0);
    check("rst_data", div_data, 16'h0000);
    check("rst_dest", div_dest_addr, 4'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", issue_ready, 1'b1);
    sync_rst_n = 1'b1;
    step(1);

    // Arithmetic vectors
    run_op("u100d7_q", 16'd100, 16'd7, 1'b0, 1'b0, 4'd3, 16'h000E, 18);
    run_op("u100d7_r", 16'd100, 16'd7, 1'b0, 1'b1, 4'd3, 16'h0002, 18);
    run_op("sm7d2_q", 16'hFFF9, 16'h0002, 1'b1, 1'b0, 4'd5, 16'hFFFD, 18);
    run_op("sm7d2_r", 16'hFFF9, 16'h0002, 1'b1, 1'b1, 4'd5, 16'hFFFF, 18);
    run_op("s7dm2_r", 16'h0007, 16'hFFFE, 1'b1, 1'b1, 4'd6, 16'h0001, 18);
    run_op("uFFF9d2_q", 16'hFFF9, 16'h0002, 1'b0, 1'b0, 4'd7, 16'h7FFC, 18);
    run_op("sovf_q", 16'h8000, 16'hFFFF, 1'b1, 1'b0, 4'd8, 16'h8000, 18);
    run_op("sovf_r", 16'h8000, 16'hFFFF, 1'b1, 1'b1, 4'd8, 16'h0000, 18);
    run_op("x0_dest", 16'd9, 16'd3, 1'b0, 1'b0, 4'd0, 16'h0003, 18);

    // Divide by zero
    run_op("dz_u_q", 16'h04D2, 16'h0000, 1'b0, 1'b0, 4'd9, 16'hFFFF, 2);
    run_op("dz_s_q", 16'h04D2, 16'h0000, 1'b1, 1'b0, 4'd9, 16'hFFFF, 2);
    run_op("dz_s_r", 16'h04D2, 16'h0000, 1'b1, 1'b1, 4'd9, 16'h04D2, 2);

    // Stall hold with a competing issue attempt
    issue(16'd100, 16'd7, 1'b0, 1'b0, 4'd2);
    wait_valid(40);
    check("stall_lat", lat, 18);
    held = div_data;
    wb_stall = 1'b1;
    issue_valid = 1'b1;
    dividend = 16'd50; divisor = 16'd5;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        wb_stall = 1'b0;
        issue_valid = 1'b0;
      end
      check("stall_valid", div_valid, 1'b1);
      check("stall_data", div_data, held);
      check("stall_ready", issue_ready, 1'b0);
      @(negedge clk);
    end
    check("stall_valid_drop", div_valid, 1'b0);
    check("stall_no_accept", busy, 1'b0);

    // Flush overriding a handshake in IDLE
    issue_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    issue_valid = 1'b0;
    flush = 1'b0;
    check("flush_issue_busy", busy, 1'b0);
    check("flush_issue_ready", issue_ready, 1'b1);

    // Flush during ITER cycle 5, then a fresh op
    issue(16'd1000, 16'd3, 1'b0, 1'b0, 4'd4);
    step(4);
    check("flush_mid_busy_pre", busy, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_mid_busy", busy, 1'b0);
    check("flush_mid_valid", div_valid, 1'b0);
    run_op("post_flush", 16'd1000, 16'd3, 1'b0, 1'b0, 4'd4, 16'd333, 18);

    // Flush while a result is held in DONE
    issue(16'd20, 16'd4, 1'b0, 1'b0, 4'd1);
    wb_stall = 1'b1;
    wait_valid(40);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wb_stall = 1'b0;
    check("flush_done_valid", div_valid, 1'b0);
    check("flush_done_busy", busy, 1'b0);

    // Reset during ITER
    issue(16'd1000, 16'd3, 1'b0, 1'b0, 4'd4);
    step(4);
    sync_rst_n = 1'b0;
    @(negedge clk);
    sync_rst_n = 1'b1;
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_ready", issue_ready, 1'b1);
    check("rst_mid_valid", div_valid, 1'b0);
    check("rst_mid_data", div_data, 16'h0000);
    check("rst_mid_dest", div_dest_addr, 4'd0);
    run_op("post_rst", 16'd1000, 16'd3, 1'b0, 1'b1, 4'd4, 16'd1, 18);

    // Clock enable low for 4 cycles mid-ITER: result 4 cycles later, same value
    issue(16'd100, 16'd7, 1'b0, 1'b0, 4'd3);
    step(5);
    clk_en = 1'b0;
    step(4);
    clk_en = 1'b1;
    wait_valid(40);
    check("cen_lat", lat, 22);
    check("cen_data", div_data, 16'h000E);
    check("cen_dest", div_dest_addr, 4'd3);
    @(negedge clk);
    check("cen_valid_drop", div_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_unit_m1.md
# div_unit_m1

Iterative 16-bit integer divider that produces the `div_data` / `div_dest_addr` / `div_valid` operands of the writeback stage. It accepts one operation at a time from issue over a valid/ready handshake and computes the quotient or remainder, signed or unsigned, using a radix-2 restoring algorithm. It holds its result until the writeback stage accepts it, which is the first enabled cycle with `wb_stall` low.

## Interface
Parameters: none. Widths are fixed at 16-bit data and 4-bit register addresses.

- `clk` in 1: single clock; all state changes on its rising edge.
- `sync_rst_n` in 1: synchronous, active-low reset. It takes priority over `clk_en`.
- `clk_en` in 1: global enable. When low, all state is frozen.
- `flush` in 1: synchronous abort of any in-flight or held operation.
- `issue_valid` in 1: an operation is offered.
- `issue_ready` out 1: the divider can accept an operation. Equals (state == IDLE).
- `dividend` in 16: numerator.
- `divisor` in 16: denominator.
- `is_signed` in 1: 1 = two's-complement operands, 0 = unsigned.
- `want_rem` in 1: 1 = return the remainder, 0 = return the quotient.
- `dest_addr` in 4: destination register, carried through to the result unchanged.
- `wb_stall` in 1: writeback conflict stall. While high, the result must be held.
- `div_data` out 16: result value.
- `div_dest_addr` out 4: result destination register.
- `div_valid` out 1: result pending for writeback.
- `busy` out 1: state != IDLE.

## Operation
- FSM states are IDLE, PREP, ITER, FIX and DONE. All transitions require `clk_en` = 1.
- **IDLE:** on `issue_valid` && `issue_ready`, latch the operands, `is_signed`, `want_rem` and `dest_addr`, then go to PREP.
- **PREP:**
  - Record `neg_q` = `is_signed` & (dividend[15] ^ divisor[15]).
  - Record `neg_r` = `is_signed` & dividend[15].
  - Replace each operand with its absolute value when `is_signed`.
  - Clear the 17-bit partial remainder and load the 4-bit counter with 15.
  - If divisor == 0, go to FIX with quotient = 0xFFFF and remainder = the original dividend, and skip the sign fix. Otherwise go to ITER.
- **ITER** (one bit per cycle):
  - Shift {rem, quo} left by 1, shifting in a 0.
  - If rem ≥ |divisor|, subtract |divisor| from rem and set the quotient LSB.
  - When the counter reaches 0, go to FIX; otherwise decrement the counter.
- **FIX:**
  - Negate the quotient if `neg_q`, negate the remainder if `neg_r`. The divide-by-zero path does neither.
  - Select the quotient or remainder per `want_rem`.
  - Load `div_data`, load `div_dest_addr`, set `div_valid` = 1, and go to DONE.
- **DONE:** hold all outputs. On the first cycle with `clk_en` && !`wb_stall`, clear `div_valid` and go to IDLE.
- **Arithmetic rules:**
  - The magnitude of 0x8000 is 0x8000, treated as unsigned.
  - Signed overflow 0x8000 / 0xFFFF yields quotient 0x8000 and remainder 0x0000 with no special case.
  - The remainder's sign follows the dividend.
- **Destination x0:** `dest_addr` = 0 is computed normally and presented with `div_valid` = 1. Writeback discards it.
- **Flush:**
  - With `clk_en`, `flush` forces IDLE, clears `div_valid`, and discards the operation, including one in DONE.
  - It overrides an issue handshake in the same cycle: no operation is accepted.
- **Reset:**
  - `sync_rst_n` low forces IDLE, from any state including mid-ITER.
  - Reset values: `div_valid` = 0, `div_data` = 0x0000, `div_dest_addr` = 0, `busy` = 0, `issue_ready` = 1.

## Timing
- Handshake at edge N. Cycles with `clk_en` low do not count.
  - Normal path: `div_valid` rises after edge N+18 (PREP 1, ITER 16, FIX 1).
  - Divide by zero: `div_valid` rises after edge N+2.
- `div_valid` stays high for at least one cycle. Each cycle with `wb_stall` high, or with `clk_en` low, adds one cycle.
- `div_data` and `div_dest_addr` are stable for as long as `div_valid` is high.
- `issue_ready` returns high the cycle after the result is consumed.
  - Minimum issue-to-issue spacing: 20 cycles (normal), 4 cycles (divide by zero).
- `issue_ready` and `busy` are combinational from the state register only. There is no input-to-output combinational path.

## Test plan
- **Unsigned divide:** unsigned 100 / 7, `want_rem` = 0, dest 3.
  - `div_valid` after N+18 with `div_data` = 0x000E, `div_dest_addr` = 3, then low the next cycle.
  - Repeat with `want_rem` = 1: `div_data` = 0x0002.
- **Signed divide:** signed 0xFFF9 / 0x0002 (-7 / 2).
  - Quotient 0xFFFD (-3); with `want_rem` = 1, remainder 0xFFFF (-1).
  - Signed 0x8000 / 0xFFFF: quotient 0x8000, remainder 0x0000.
- **Divide by zero:** 0x04D2 / 0.
  - Quotient 0xFFFF after N+2, both signed and unsigned.
  - Remainder 0x04D2.
- **Stall hold:** hold `wb_stall` high for 3 cycles after `div_valid` rises.
  - `div_valid` stays high for exactly 4 cycles with data constant, and `issue_ready` stays low.
  - A second `issue_valid` during this time is not accepted.
- **Flush and reset:**
  - `flush` at ITER cycle 5: `div_valid` never rises and IDLE is reached after that edge. A new op issued next cycle returns the correct result at +18.
  - `sync_rst_n` low mid-ITER: same behaviour, and all outputs are at reset values.
- **Clock enable:** `clk_en` low for 4 cycles mid-ITER.
  - The result appears 4 cycles later than N+18 and the value is unchanged.
